// File: rtl/load_upper_unit.sv
// Upper-immediate / PC-relative result unit: computes LUI, AUIPC and link
// results behind a registered output stage with a one-entry skid buffer.
module load_upper_unit #(
   parameter int XLEN     = 32,
   parameter int LINK_INC = 4,
   parameter int TAG_W    = 5
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic             i_Valid,
   output logic             o_Ready,
   input  logic [1:0]       i_OpCode,
   input  logic [XLEN-1:0]  i_PC,
   input  logic [XLEN-1:0]  i_Imm,
   input  logic [TAG_W-1:0] i_Tag,
   output logic             o_Valid,
   input  logic             i_Ready,
   output logic [XLEN-1:0]  o_Result,
   output logic [TAG_W-1:0] o_Tag,
   output logic             o_Illegal
);

   localparam logic [XLEN-1:0] LINK_ADD = XLEN'(LINK_INC);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;
   logic [XLEN-1:0]  skid_result;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_illegal;

   logic [XLEN-1:0]  new_result;
   logic             new_illegal;
   logic             in_xfer;
   logic             out_xfer;

   // Handshake flags come straight from the registered state, so i_Ready
   // never reaches o_Ready combinationally.
   assign o_Ready  = (state != TWO);
   assign o_Valid  = (state != EMPTY);
   assign in_xfer  = i_Valid && o_Ready;
   assign out_xfer = o_Valid && i_Ready;

   assign o_Result  = out_result;
   assign o_Tag     = out_tag;
   assign o_Illegal = out_illegal;

   always_comb begin
      new_result  = '0;
      new_illegal = 1'b0;
      case (i_OpCode)
         2'd0:    new_result = i_Imm;
         2'd1:    new_result = i_PC + i_Imm;
         2'd2:    new_result = i_PC + LINK_ADD;
         default: new_illegal = 1'b1;
      endcase
   end

   // SKID only fills from ONE with a stalled output, and always drains into
   // OUT before a newer operand can be accepted, preserving order.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state        <= EMPTY;
         out_result   <= '0;
         out_tag      <= '0;
         out_illegal  <= 1'b0;
         skid_result  <= '0;
         skid_tag     <= '0;
         skid_illegal <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  out_result  <= new_result;
                  out_tag     <= i_Tag;
                  out_illegal <= new_illegal;
                  state       <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  out_result  <= new_result;
                  out_tag     <= i_Tag;
                  out_illegal <= new_illegal;
               end else if (in_xfer) begin
                  skid_result  <= new_result;
                  skid_tag     <= i_Tag;
                  skid_illegal <= new_illegal;
                  state        <= TWO;
               end else if (out_xfer) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  out_result  <= skid_result;
                  out_tag     <= skid_tag;
                  out_illegal <= skid_illegal;
                  state       <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_load_upper_unit.sv
// Self-checking bench for load_upper_unit: directed scenarios plus random
// traffic compared against a queue-based model of the two-entry buffer.
module tb_load_upper_unit;

   localparam int XLEN     = 32;
   localparam int LINK_INC = 4;
   localparam int TAG_W    = 5;

   logic             clock = 1'b0;
   logic             reset;
   logic             inValid;
   logic             outReady;
   logic [1:0]       opCode;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  imm;
   logic [TAG_W-1:0] tag;
   logic             outValid;
   logic             downReady;
   logic [XLEN-1:0]  result;
   logic [TAG_W-1:0] outTag;
   logic             illegal;

   typedef struct packed {
      logic [XLEN-1:0]  res;
      logic [TAG_W-1:0] tg;
      logic             ill;
   } entry_t;

   entry_t model[$];
   int     errorCount = 0;
   int     checkCount = 0;
   bit     justReset  = 1'b0;

   always #5 clock = ~clock;

   load_upper_unit #(.XLEN(XLEN), .LINK_INC(LINK_INC), .TAG_W(TAG_W)) dut (
      .i_Clk    (clock),
      .i_Rst    (reset),
      .i_Valid  (inValid),
      .o_Ready  (outReady),
      .i_OpCode (opCode),
      .i_PC     (pc),
      .i_Imm    (imm),
      .i_Tag    (tag),
      .o_Valid  (outValid),
      .i_Ready  (downReady),
      .o_Result (result),
      .o_Tag    (outTag),
      .o_Illegal(illegal)
   );

   // Architectural meaning of each opcode, wrapped to XLEN bits.
   function automatic entry_t refEntry(input logic [1:0] op, input logic [XLEN-1:0] p,
                                       input logic [XLEN-1:0] i, input logic [TAG_W-1:0] t);
      entry_t e;
      longint unsigned sum;
      e.tg  = t;
      e.ill = 1'b0;
      case (op)
         2'd0: e.res = i;
         2'd1: begin sum = longint'(p) + longint'(i); e.res = sum[XLEN-1:0]; end
         2'd2: begin sum = longint'(p) + LINK_INC;    e.res = sum[XLEN-1:0]; end
         default: begin e.res = '0; e.ill = 1'b1; end
      endcase
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Called at a falling edge: checks outputs, drives inputs, advances one
   // rising edge, updates the model, and returns at the next falling edge.
   task automatic applyStimulus(input bit rst, input bit valid, input logic [1:0] op,
                                input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                                input logic [TAG_W-1:0] t, input bit ready);
      bit accept;
      bit deliver;
      checkOutput("o_Valid", 64'(outValid), 64'(model.size() > 0));
      checkOutput("o_Ready", 64'(outReady), 64'(model.size() < 2));
      if (model.size() > 0) begin
         checkOutput("o_Result", 64'(result), 64'(model[0].res));
         checkOutput("o_Tag", 64'(outTag), 64'(model[0].tg));
         checkOutput("o_Illegal", 64'(illegal), 64'(model[0].ill));
      end else if (justReset) begin
         checkOutput("rst_Result", 64'(result), 64'd0);
         checkOutput("rst_Tag", 64'(outTag), 64'd0);
         checkOutput("rst_Illegal", 64'(illegal), 64'd0);
      end
      reset     = rst;
      inValid   = valid;
      opCode    = op;
      pc        = p;
      imm       = i;
      tag       = t;
      downReady = ready;
      accept    = valid && (model.size() < 2);
      deliver   = (model.size() > 0) && ready;
      @(posedge clock);
      if (rst) begin
         model.delete();
         justReset = 1'b1;
      end else begin
         if (deliver) void'(model.pop_front());
         if (accept) begin
            model.push_back(refEntry(op, p, i, t));
            justReset = 1'b0;
         end
      end
      @(negedge clock);
   endtask

   task automatic idle(input bit ready);
      applyStimulus(1'b0, 1'b0, 2'd0, '0, '0, '0, ready);
   endtask

   initial begin
      reset = 1'b1; inValid = 1'b0; opCode = '0; pc = '0; imm = '0; tag = '0; downReady = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      justReset = 1'b1;

      // Basic LUI, then back to empty
      applyStimulus(0, 1, 2'd0, 32'h0, 32'h12345000, 5'd3, 1);
      idle(1);
      idle(1);

      // Wrap-around for AUIPC and LINK
      applyStimulus(0, 1, 2'd1, 32'hFFFFF000, 32'h00002000, 5'd4, 1);
      applyStimulus(0, 1, 2'd2, 32'hFFFFFFFC, 32'h0, 5'd5, 1);
      idle(1);
      idle(1);

      // Back-to-back stream
      for (int k = 0; k < 8; k++)
         applyStimulus(0, 1, 2'(k % 3), 32'h1000 * k, 32'h00010000 * (k + 1), 5'(k + 8), 1);
      idle(1);
      idle(1);

      // Stall with A, B, then C held off until space frees up
      applyStimulus(0, 1, 2'd0, 32'h0, 32'hAAAAA000, 5'd1, 0);
      applyStimulus(0, 1, 2'd0, 32'h0, 32'hBBBBB000, 5'd2, 0);
      applyStimulus(0, 1, 2'd0, 32'h0, 32'hCCCCC000, 5'd3, 0);
      applyStimulus(0, 1, 2'd0, 32'h0, 32'hCCCCC000, 5'd3, 0);
      applyStimulus(0, 1, 2'd0, 32'h0, 32'hCCCCC000, 5'd3, 1);
      applyStimulus(0, 1, 2'd0, 32'h0, 32'hCCCCC000, 5'd3, 1);
      idle(1);
      idle(1);

      // Reserved opcode followed by a legal LUI
      applyStimulus(0, 1, 2'd3, 32'h1234, 32'h5678, 5'd7, 1);
      applyStimulus(0, 1, 2'd0, 32'h0, 32'h00055000, 5'd9, 1);
      idle(1);
      idle(1);

      // Fill to two entries, reset, then a fresh LUI with no stale data
      applyStimulus(0, 1, 2'd1, 32'h100, 32'h2000, 5'd11, 0);
      applyStimulus(0, 1, 2'd2, 32'h200, 32'h0, 5'd12, 0);
      applyStimulus(1, 1, 2'd0, 32'h0, 32'hDEAD0000, 5'd13, 0);
      applyStimulus(0, 1, 2'd0, 32'h0, 32'h0000A000, 5'd14, 1);
      idle(1);
      idle(1);

      // Random traffic with occasional resets
      for (int k = 0; k < 400; k++)
         applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                       2'($urandom_range(0, 3)), $urandom, $urandom,
                       TAG_W'($urandom), $urandom_range(0, 2) != 0);
      for (int k = 0; k < 4; k++) idle(1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
